// File: rtl/multiplier_pkg.sv
// Shared types, parameter limits and the operand-extension helper for the
// pipelined multiplier.
//
// Contents:
//   mul_mode_t       per-transaction arithmetic mode (unsigned / signed)
//   MIN_*            lower bounds checked at elaboration by the top level
//   EXT_MAX_WIDTH    widest operand extend_operand can handle
//   extend_operand   zero- or sign-extends an operand to twice its width
package multiplier_pkg;

    typedef enum logic {
        MUL_UNSIGNED = 1'b0,
        MUL_SIGNED   = 1'b1
    } mul_mode_t;

    localparam int MIN_STAGES    = 1;
    localparam int MIN_WIDTH     = 2;
    localparam int MIN_TAG_WIDTH = 1;
    localparam int EXT_MAX_WIDTH = 64;

    // Extends a WIDTH-bit operand (right-aligned in value, upper bits zero)
    // to the full product width. The caller truncates the returned vector
    // to 2*WIDTH bits.
    function automatic logic [2*EXT_MAX_WIDTH-1:0] extend_operand(
        input logic [EXT_MAX_WIDTH-1:0] value,
        input int unsigned              width,
        input mul_mode_t                mode
    );
        logic [2*EXT_MAX_WIDTH-1:0] ext;
        ext = {{EXT_MAX_WIDTH{1'b0}}, value};
        if (mode == MUL_SIGNED && value[width-1]) begin
            ext = ext | ({(2*EXT_MAX_WIDTH){1'b1}} << width);
        end
        return ext;
    endfunction

endpackage

// File: rtl/multiplier_stage.sv
// One elastic register slice of the multiplier pipeline.
//
// Ports:
//   clock_i, reset_i   rising-edge clock, synchronous active-high reset
//   valid_i, data_i    upstream slot
//   ready_o            this slice can take a new word this cycle
//   valid_o, data_o    registered slot contents
//   ready_i            downstream accepts the registered word
//
// RESET_DATA selects whether the data register is cleared by reset (only
// the slice that drives the block outputs needs it).
module multiplier_stage #(
    parameter int DATA_WIDTH = 8,
    parameter bit RESET_DATA = 1'b0
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  ready_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  ready_i
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    // An empty slice always accepts, so bubbles collapse.
    assign ready_o = !valid_q || ready_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (ready_o) begin
            valid_d = valid_i;
        end
        // Data only moves with a real transfer; a stalled word stays put.
        if (ready_o && valid_i) begin
            data_d = data_i;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (RESET_DATA && reset_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipelined_multiplier.sv
// Fully pipelined WIDTH x WIDTH integer multiplier with valid/ready
// handshakes, per-operation signed/unsigned mode and a pass-through tag.
// The exact 2*WIDTH-bit product is formed combinationally, then carried
// through STAGES elastic register slices; the last slice drives out_*.
//
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   in_valid / in_ready          operand handshake
//   in_a, in_b, in_signed        operands and mode (1 = two's complement)
//   in_tag                       returned unchanged with the result
//   in_accumulate                (MULTIPLIER_ACCUM_EN only) add product to accumulator
//   out_valid / out_ready        result handshake
//   out_product, out_tag         result and its tag
//
// Build option: define MULTIPLIER_ACCUM_EN to add in_accumulate and a
// 2*WIDTH-bit running accumulator applied as an op enters the last slice.
module pipelined_multiplier
    import multiplier_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int STAGES    = 3,
    parameter int TAG_WIDTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    input  logic                   in_signed,
    input  logic [TAG_WIDTH-1:0]   in_tag,
`ifdef MULTIPLIER_ACCUM_EN
    input  logic                   in_accumulate,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*WIDTH-1:0]     out_product,
    output logic [TAG_WIDTH-1:0]   out_tag
);

    localparam int PW = 2 * WIDTH;
`ifdef MULTIPLIER_ACCUM_EN
    localparam int DW = PW + TAG_WIDTH + 1;  // {accumulate, tag, product}
`else
    localparam int DW = PW + TAG_WIDTH;      // {tag, product}
`endif

    if (STAGES < MIN_STAGES) begin : g_bad_stages
        $error("pipelined_multiplier: STAGES must be at least %0d", MIN_STAGES);
    end
    if (WIDTH < MIN_WIDTH || WIDTH > EXT_MAX_WIDTH) begin : g_bad_width
        $error("pipelined_multiplier: WIDTH out of range");
    end
    if (TAG_WIDTH < MIN_TAG_WIDTH) begin : g_bad_tag
        $error("pipelined_multiplier: TAG_WIDTH must be at least %0d", MIN_TAG_WIDTH);
    end

    // Full-precision product ahead of slice 0. Multiplying the extended
    // operands modulo 2^PW gives the exact result in both modes, including
    // (-2^(WIDTH-1))^2.
    mul_mode_t         mode;
    logic [PW-1:0]     a_ext, b_ext, prod;
    logic [DW-1:0]     head_data;

    assign mode  = in_signed ? MUL_SIGNED : MUL_UNSIGNED;
    assign a_ext = PW'(extend_operand(EXT_MAX_WIDTH'(in_a), WIDTH, mode));
    assign b_ext = PW'(extend_operand(EXT_MAX_WIDTH'(in_b), WIDTH, mode));
    assign prod  = a_ext * b_ext;

`ifdef MULTIPLIER_ACCUM_EN
    assign head_data = {in_accumulate, in_tag, prod};

    logic [PW-1:0] acc_q, acc_d;
    logic          acc_load;

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q <= '0;
        end else if (acc_load) begin
            acc_q <= acc_d;
        end
    end
`else
    assign head_data = {in_tag, prod};
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        logic          vld_in, rdy, rdy_dn, vld_q;
        logic [DW-1:0] dat_up, dat_in, dat_q;

        if (k == 0) begin : g_head
            assign vld_in = in_valid;
            assign dat_up = head_data;
        end else begin : g_link
            assign vld_in = g_slice[k-1].vld_q;
            assign dat_up = g_slice[k-1].dat_q;
        end

        if (k == STAGES - 1) begin : g_tail
            assign rdy_dn = out_ready;
`ifdef MULTIPLIER_ACCUM_EN
            // The accumulator is folded in as the op enters the last slice,
            // so updates follow acceptance order exactly.
            logic [PW-1:0] acc_sum;
            assign acc_sum  = dat_up[DW-1] ? dat_up[PW-1:0] + acc_q : dat_up[PW-1:0];
            assign dat_in   = {dat_up[DW-1:PW], acc_sum};
            assign acc_load = vld_in && rdy;
            assign acc_d    = acc_sum;
`else
            assign dat_in = dat_up;
`endif
        end else begin : g_body
            assign rdy_dn = g_slice[k+1].rdy;
            assign dat_in = dat_up;
        end

        multiplier_stage #(
            .DATA_WIDTH (DW),
            .RESET_DATA (k == STAGES - 1)
        ) u_stage (
            .clock_i (clock),
            .reset_i (reset),
            .valid_i (vld_in),
            .data_i  (dat_in),
            .ready_o (rdy),
            .valid_o (vld_q),
            .data_o  (dat_q),
            .ready_i (rdy_dn)
        );
    end

    assign in_ready    = g_slice[0].rdy;
    assign out_valid   = g_slice[STAGES-1].vld_q;
    assign out_product = g_slice[STAGES-1].dat_q[PW-1:0];
    assign out_tag     = g_slice[STAGES-1].dat_q[PW+TAG_WIDTH-1:PW];

endmodule

// File: tb/tb_pipelined_multiplier.sv
// Scoreboard bench for pipelined_multiplier (WIDTH=8, STAGES=3, TAG_WIDTH=4).
module tb_pipelined_multiplier;

    localparam int W  = 8;
    localparam int S  = 3;
    localparam int TW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          in_signed = 1'b0;
    logic [TW-1:0] in_tag = '0;
    logic          in_accumulate = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [2*W-1:0] out_product;
    logic [TW-1:0] out_tag;

    pipelined_multiplier #(
        .WIDTH     (W),
        .STAGES    (S),
        .TAG_WIDTH (TW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_a          (in_a),
        .in_b          (in_b),
        .in_signed     (in_signed),
        .in_tag        (in_tag),
`ifdef MULTIPLIER_ACCUM_EN
        .in_accumulate (in_accumulate),
`endif
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_product   (out_product),
        .out_tag       (out_tag)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [2*W-1:0] prod;
        logic [TW-1:0]  tag;
        int             cyc;
        bit             lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   not_ready_cnt = 0;

    // Expectation for the operation currently presented by the driver.
    logic [2*W-1:0] cur_lit = '0;
    bit             cur_use_lit = 1'b0;
    bit             cur_lat = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic sgn);
        int ia, ib, p;
        ia = sgn ? int'($signed(a)) : int'(a);
        ib = sgn ? int'($signed(b)) : int'(b);
        p  = ia * ib;
        return p[2*W-1:0];
    endfunction

    // Monitor / scoreboard, sampled on the falling edge.
    exp_t           mon_e;
    exp_t           push_e;
    logic [2*W-1:0] acc_m = '0;
    bit             stall_prev = 1'b0;
    logic [2*W-1:0] hold_prod = '0;
    logic [TW-1:0]  hold_tag = '0;

    always @(negedge clock) begin
        if (reset) begin
            sb.delete();
            acc_m = '0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_product", 32'(out_product), 32'(hold_prod));
                check("hold_tag", 32'(out_tag), 32'(hold_tag));
            end
            stall_prev = out_valid && !out_ready;
            hold_prod  = out_product;
            hold_tag   = out_tag;
            if (!in_ready) not_ready_cnt++;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("product", 32'(out_product), 32'(mon_e.prod));
                    check("tag", 32'(out_tag), 32'(mon_e.tag));
                    if (mon_e.lat) check("latency", 32'(cyc - mon_e.cyc), 32'(S));
                end
            end
            if (in_valid && in_ready) begin
                push_e.prod = cur_use_lit ? cur_lit : model(in_a, in_b, in_signed);
`ifdef MULTIPLIER_ACCUM_EN
                if (!cur_use_lit && in_accumulate) push_e.prod = push_e.prod + acc_m;
                acc_m = push_e.prod;
`endif
                push_e.tag = in_tag;
                push_e.cyc = cyc;
                push_e.lat = cur_lat;
                sb.push_back(push_e);
            end
        end
    end

    // Presents one op and returns #1 after the edge that accepted it.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                        input logic [TW-1:0] tag, input logic acc,
                        input logic [2*W-1:0] lit, input bit use_lit, input bit lat);
        bit done;
        in_valid = 1'b1; in_a = a; in_b = b; in_signed = sgn; in_tag = tag;
        in_accumulate = acc;
        cur_lit = lit; cur_use_lit = use_lit; cur_lat = lat;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clock);
            if (in_ready) begin
                @(posedge clock);
                #1;
                done = 1'b1;
            end
        end
        if (!done) begin
            check("send_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        bit done;
        in_valid = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(posedge clock);
            #2;
            if (sb.size() == 0 && !out_valid) done = 1'b1;
        end
        if (!done) check("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    int nr_before;

    initial begin
        // Reset and post-reset state
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_product", 32'(out_product), 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clock);
        #1;

        // Directed arithmetic cases, back to back
        send(8'hFD, 8'h05, 1'b1, 4'h2, 1'b0, 16'hFFF1, 1'b1, 1'b1);
        send(8'hFD, 8'h05, 1'b0, 4'h3, 1'b0, 16'h04F1, 1'b1, 1'b1);
        send(8'h80, 8'h80, 1'b1, 4'h4, 1'b0, 16'h4000, 1'b1, 1'b1);
        send(8'hFF, 8'hFF, 1'b0, 4'h5, 1'b0, 16'hFE01, 1'b1, 1'b1);
        send(8'h00, 8'h7F, 1'b0, 4'h6, 1'b0, 16'h0000, 1'b1, 1'b1);
        send(8'hFF, 8'hFF, 1'b1, 4'h7, 1'b0, 16'h0001, 1'b1, 1'b1);
        send(8'h7F, 8'h80, 1'b1, 4'h8, 1'b0, 16'hC080, 1'b1, 1'b1);
        wait_drain();

        // Full-rate stream: latency S on every op and no input stall
        nr_before = not_ready_cnt;
        for (int i = 0; i < 8; i++) begin
            send(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1'(i),
                 TW'(i), 1'b0, '0, 1'b0, 1'b1);
        end
        wait_drain();
        check("full_rate_in_ready", 32'(not_ready_cnt - nr_before), 32'd0);

        // Same stream with the consumer stalled for six cycles
        nr_before = not_ready_cnt;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1'(i + 1),
                         TW'(i), 1'b0, '0, 1'b0, 1'b0);
                end
                in_valid = 1'b0;
            end
            begin
                repeat (4) @(posedge clock);
                #1 out_ready = 1'b0;
                repeat (6) @(posedge clock);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain();
        check("stall_in_ready_fell", 32'(not_ready_cnt > nr_before), 32'd1);

        // Reset with two ops in flight and a new op offered during reset
        send(8'h12, 8'h34, 1'b0, 4'hA, 1'b0, '0, 1'b0, 1'b0);
        send(8'h56, 8'h78, 1'b1, 4'hB, 1'b0, '0, 1'b0, 1'b0);
        in_a = 8'h11; in_b = 8'h22; in_tag = 4'hC;
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        in_valid = 1'b0;
        #1;
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clock);
            #2;
            check("flushed_out_valid", 32'(out_valid), 32'd0);
        end

`ifdef MULTIPLIER_ACCUM_EN
        send(8'd2, 8'd3, 1'b0, 4'h1, 1'b0, 16'd6,  1'b1, 1'b1);
        send(8'd4, 8'd5, 1'b0, 4'h2, 1'b1, 16'd26, 1'b1, 1'b1);
        send(8'd1, 8'd1, 1'b0, 4'h3, 1'b1, 16'd27, 1'b1, 1'b1);
        wait_drain();
`endif

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
